// File: rtl/uart_pkg.sv
// Shared UART types: parity mode, TX FSM states and the baud NCO increment helper.
// ST_BREAK exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
`ifdef UART_TX_BREAK_EN
    , ST_BREAK
`endif
  } tx_state_t;

  // Rounded phase increment so the accumulator carries at BAUD_RATE on average.
  function automatic int nco_incr(real clk_freq, real baud, int width);
    return $rtoi((2.0 ** width) * baud / clk_freq + 0.5);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with show-ahead read data; latency 1 clk write-to-empty-deassert.
// Backpressure: writes when full and reads when empty are ignored; caller watches full/empty.
module uart_sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      level <= level + 1'b1;
      else if (!do_wr && do_rd) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter (optional line break via UART_TX_BREAK_EN); start bit <= 1 baud period + 2 clk after push.
// Backpressure: ready = FIFO not full; a write while not ready is dropped and pulses overflow.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter real     CLK_FREQ   = 100E6,
  parameter int      NCO_WIDTH  = 16,
  parameter real     BAUD_RATE  = 115200,
  parameter int      DATA_BITS  = 8,
  parameter int      STOP_BITS  = 1,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      FIFO_DEPTH = 16,
  localparam int     LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dvld,
  input  logic [DATA_BITS-1:0] data,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_req,
`endif
  output logic                 ready,
  output logic                 overflow,
  output logic                 busy,
  output logic [LW-1:0]        fifo_level,
  output logic                 uart_tx
);

  localparam int         NCO_INCR  = nco_incr(CLK_FREQ, BAUD_RATE, NCO_WIDTH);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (dvld),
    .wr_data (data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign ready = !fifo_full;

  logic [NCO_WIDTH-1:0] nco_acc;
  logic [NCO_WIDTH:0]   nco_sum;
  logic                 baud_en;

  assign nco_sum = {1'b0, nco_acc} + (NCO_WIDTH+1)'(NCO_INCR);
  assign baud_en = nco_sum[NCO_WIDTH];

  tx_state_t            state, state_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par_bit, par_d;
  logic [2:0]           bit_cnt, cnt_d;
  logic                 tx_d;
  logic                 load;

  always_ff @(posedge clk) begin
    if (rst) begin
      nco_acc  <= '0;
      state    <= ST_IDLE;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      uart_tx  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      nco_acc  <= nco_sum[NCO_WIDTH-1:0];
      state    <= state_d;
      shreg    <= shreg_d;
      par_bit  <= par_d;
      bit_cnt  <= cnt_d;
      uart_tx  <= tx_d;
      overflow <= dvld && fifo_full;
    end
  end

  // Every transition is gated by baud_en so each line level lasts one tick interval.
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    par_d   = par_bit;
    cnt_d   = bit_cnt;
    tx_d    = uart_tx;
    load    = 1'b0;
    pop     = 1'b0;
    if (baud_en) begin
      case (state)
        ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            state_d = ST_BREAK;
            tx_d    = 1'b0;
          end else
`endif
          if (!fifo_empty) load = 1'b1;
        end
        ST_START: begin
          state_d = ST_DATA;
          tx_d    = shreg[0];
          shreg_d = shreg >> 1;
          cnt_d   = '0;
        end
        ST_DATA: begin
          if (bit_cnt == LAST_DATA) begin
            cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d    = shreg[0];
            shreg_d = shreg >> 1;
            cnt_d   = bit_cnt + 3'd1;
          end
        end
        ST_PARITY: begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
        ST_STOP: begin
          if (bit_cnt == LAST_STOP) begin
            if (!fifo_empty) load = 1'b1;
            else             state_d = ST_IDLE;
          end else begin
            cnt_d = bit_cnt + 3'd1;
          end
        end
`ifdef UART_TX_BREAK_EN
        // Leaving break goes through STOP so the line is high before any frame.
        ST_BREAK: begin
          if (!break_req) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
            cnt_d   = '0;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
    if (load) begin
      pop     = 1'b1;
      shreg_d = head;
      par_d   = (PARITY == PAR_ODD) ? ~^head : ^head;
      state_d = ST_START;
      tx_d    = 1'b0;
    end
  end

  assign busy = (state != ST_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: one slow 8N1 instance at 115200 baud and three fast
// instances at 16 clk/bit (8E1, 8O1, 7E2); break test runs when UART_TX_BREAK_EN is defined.
module tb_uart_tx_buf;
  import uart_pkg::*;

  localparam int ND = 4;

  typedef struct {
    int          dut;
    logic [7:0]  dat;
    int          nbits;
    logic [15:0] exp;
  } frame_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [ND];
  logic       dvld_v  [ND];
  logic [7:0] data_v  [ND];
  logic       ready_v [ND];
  logic       ovf_v   [ND];
  logic       busy_v  [ND];
  logic       tx_v    [ND];
  logic [4:0] lvl_v   [ND];
`ifdef UART_TX_BREAK_EN
  logic       brk_v   [ND];
`endif
  int per [ND] = '{874, 16, 16, 16};

  int n_vec = 0;
  int n_err = 0;

  uart_tx_buf u_slow (
    .clk (clk), .rst (rst_v[0]), .dvld (dvld_v[0]), .data (data_v[0]),
`ifdef UART_TX_BREAK_EN
    .break_req (brk_v[0]),
`endif
    .ready (ready_v[0]), .overflow (ovf_v[0]), .busy (busy_v[0]),
    .fifo_level (lvl_v[0]), .uart_tx (tx_v[0])
  );

  uart_tx_buf #(.BAUD_RATE(6.25E6), .PARITY(PAR_EVEN)) u_even (
    .clk (clk), .rst (rst_v[1]), .dvld (dvld_v[1]), .data (data_v[1]),
`ifdef UART_TX_BREAK_EN
    .break_req (brk_v[1]),
`endif
    .ready (ready_v[1]), .overflow (ovf_v[1]), .busy (busy_v[1]),
    .fifo_level (lvl_v[1]), .uart_tx (tx_v[1])
  );

  uart_tx_buf #(.BAUD_RATE(6.25E6), .PARITY(PAR_ODD)) u_odd (
    .clk (clk), .rst (rst_v[2]), .dvld (dvld_v[2]), .data (data_v[2]),
`ifdef UART_TX_BREAK_EN
    .break_req (brk_v[2]),
`endif
    .ready (ready_v[2]), .overflow (ovf_v[2]), .busy (busy_v[2]),
    .fifo_level (lvl_v[2]), .uart_tx (tx_v[2])
  );

  uart_tx_buf #(.BAUD_RATE(6.25E6), .DATA_BITS(7), .STOP_BITS(2), .PARITY(PAR_EVEN)) u_7e2 (
    .clk (clk), .rst (rst_v[3]), .dvld (dvld_v[3]), .data (data_v[3][6:0]),
`ifdef UART_TX_BREAK_EN
    .break_req (brk_v[3]),
`endif
    .ready (ready_v[3]), .overflow (ovf_v[3]), .busy (busy_v[3]),
    .fifo_level (lvl_v[3]), .uart_tx (tx_v[3])
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int got, input int lo, input int hi);
    n_vec++;
    if (got < lo || got > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, got, lo, hi);
    end
  endtask

  task automatic write_byte(input int d, input logic [7:0] b);
    data_v[d] = b;
    dvld_v[d] = 1'b1;
    step(1);
    dvld_v[d] = 1'b0;
  endtask

  task automatic wait_fall(input int d, input string nm);
    int w = 0;
    while (tx_v[d] !== 1'b0 && w < per[d] + 10) begin
      step(1);
      w++;
    end
    check_rng({nm, "_start_latency"}, w, 0, per[d] + 2);
  endtask

  task automatic sample(input int d, input int nbits, input int first, output logic [15:0] got);
    got = '0;
    step(first);
    got[0] = tx_v[d];
    for (int i = 1; i < nbits; i++) begin
      step(per[d]);
      got[i] = tx_v[d];
    end
  endtask

  task automatic wait_idle(input int d, input string nm);
    int w = 0;
    while (busy_v[d] !== 1'b0 && w < 40 * per[d]) begin
      step(1);
      w++;
    end
    check({nm, "_idle"}, 32'(busy_v[d]), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_vec_t  vt [6];
    logic [15:0] got;
    logic        prev;
    int          ovf_cnt;
    int          cnt;

    // Line images, LSB = start bit, then data LSB first, parity, stop(s).
    vt[0] = '{1, 8'h07, 11, 16'h060E};
    vt[1] = '{2, 8'h07, 11, 16'h040E};
    vt[2] = '{1, 8'hA5, 11, 16'h054A};
    vt[3] = '{2, 8'h00, 11, 16'h0600};
    vt[4] = '{3, 8'h41, 11, 16'h0682};
    vt[5] = '{3, 8'h2A, 11, 16'h0754};

    for (int d = 0; d < ND; d++) begin
      rst_v[d]  = 1'b1;
      dvld_v[d] = 1'b0;
      data_v[d] = '0;
`ifdef UART_TX_BREAK_EN
      brk_v[d]  = 1'b0;
`endif
    end
    step(3);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst%0d_ready", d), 32'(ready_v[d]), 32'd1);
      check($sformatf("rst%0d_overflow", d), 32'(ovf_v[d]), 32'd0);
      check($sformatf("rst%0d_busy", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("rst%0d_level", d), 32'(lvl_v[d]), 32'd0);
      check($sformatf("rst%0d_tx", d), 32'(tx_v[d]), 32'd1);
      rst_v[d] = 1'b0;
    end

    // 20 back-to-back writes into the slow instance, well before its first baud tick.
    ovf_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      data_v[0] = 8'(i);
      dvld_v[0] = 1'b1;
      step(1);
      if (ovf_v[0] === 1'b1) ovf_cnt++;
      if (i == 15) check("fill_ready_after_16", 32'(ready_v[0]), 32'd0);
    end
    dvld_v[0] = 1'b0;
    step(1);
    if (ovf_v[0] === 1'b1) ovf_cnt++;
    check("fill_overflow_pulses", 32'(ovf_cnt), 32'd4);
    check("fill_level", 32'(lvl_v[0]), 32'd16);
    check("fill_ready", 32'(ready_v[0]), 32'd0);
    check("fill_busy", 32'(busy_v[0]), 32'd1);
    rst_v[0] = 1'b1;
    step(1);
    rst_v[0] = 1'b0;
    check("flush_level", 32'(lvl_v[0]), 32'd0);
    check("flush_ready", 32'(ready_v[0]), 32'd1);

    // 8N1 0x55: every bit toggles the line, so each interval is one bit time.
    write_byte(0, 8'h55);
    wait_fall(0, "t1");
    prev = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cnt = 0;
      while (tx_v[0] === prev && cnt < 1000) begin
        step(1);
        cnt++;
      end
      check_rng($sformatf("t1_bit%0d_len", k), cnt, 873, 875);
      prev = tx_v[0];
    end
    check("t1_stop_level", 32'(tx_v[0]), 32'd1);
    step(437);
    check("t1_busy_in_stop", 32'(busy_v[0]), 32'd1);
    step(440);
    check("t1_busy_after_stop", 32'(busy_v[0]), 32'd0);
    check("t1_tx_idle", 32'(tx_v[0]), 32'd1);

    foreach (vt[v]) begin
      write_byte(vt[v].dut, vt[v].dat);
      wait_fall(vt[v].dut, $sformatf("vec%0d", v));
      sample(vt[v].dut, vt[v].nbits, per[vt[v].dut] / 2, got);
      check($sformatf("vec%0d_frame", v), 32'(got), 32'(vt[v].exp));
      wait_idle(vt[v].dut, $sformatf("vec%0d", v));
    end

    // Three queued 7E2 frames must follow each other with no idle period.
    write_byte(3, 8'h41);
    write_byte(3, 8'h2A);
    write_byte(3, 8'h7F);
    wait_fall(3, "t4");
    sample(3, 11, 8, got);
    check("t4_frame0", 32'(got), 32'h0682);
    sample(3, 11, 16, got);
    check("t4_frame1", 32'(got), 32'h0754);
    sample(3, 11, 16, got);
    check("t4_frame2", 32'(got), 32'h07FE);
    wait_idle(3, "t4");

    // Reset in the middle of data bit 3 with two bytes still queued.
    write_byte(1, 8'hC3);
    write_byte(1, 8'h3C);
    write_byte(1, 8'h5A);
    wait_fall(1, "t5");
    step(8 + 4 * 16);
    check("t5_bit3_level", 32'(tx_v[1]), 32'd0);
    check("t5_queued", 32'(lvl_v[1]), 32'd2);
    rst_v[1] = 1'b1;
    step(1);
    rst_v[1] = 1'b0;
    check("t5_tx_after_rst", 32'(tx_v[1]), 32'd1);
    check("t5_level_after_rst", 32'(lvl_v[1]), 32'd0);
    check("t5_ready_after_rst", 32'(ready_v[1]), 32'd1);
    check("t5_busy_after_rst", 32'(busy_v[1]), 32'd0);
    cnt = 0;
    repeat (6 * 16) begin
      step(1);
      if (tx_v[1] !== 1'b1) cnt++;
    end
    check("t5_line_static", 32'(cnt), 32'd0);

`ifdef UART_TX_BREAK_EN
    brk_v[1] = 1'b1;
    write_byte(1, 8'h96);
    wait_fall(1, "t6");
    step(30 * 16 - 8);
    brk_v[1] = 1'b0;
    cnt = 30 * 16 - 8;
    while (tx_v[1] !== 1'b1 && cnt < 2000) begin
      step(1);
      cnt++;
    end
    check("t6_break_len", 32'(cnt), 32'd480);
    cnt = 0;
    while (tx_v[1] !== 1'b0 && cnt < 200) begin
      step(1);
      cnt++;
    end
    check("t6_high_len", 32'(cnt), 32'd16);
    sample(1, 11, 8, got);
    check("t6_frame", 32'(got), 32'h052C);
    wait_idle(1, "t6");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
